// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO register pair with multi-cycle MULT/DIV sequencing and decode-stage stall.
// Define HILO_ACCUMULATE_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10) on the MUL timing path.
module hilo_muldiv_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITER   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic        read_hilo,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = 6;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef HILO_ACCUMULATE_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_done;

  logic [63:0]        r_prod;
  logic [31:0]        r_a;
  logic               r_div0;
  logic               r_neg_a;
  logic               r_neg_b;
  logic [31:0]        r_quo;
  logic [31:0]        r_rem;
  logic [31:0]        r_dvs;
`ifdef HILO_ACCUMULATE_EN
  logic [1:0]         r_acc;
  logic [1:0]         w_acc;
`endif

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed;
  logic               w_idle;
  logic               w_accept;
  logic               w_mul_done;
  logic               w_div_done;
  logic signed [63:0] w_mul_a;
  logic signed [63:0] w_mul_b;
  logic signed [63:0] w_prod;
  logic [31:0]        w_abs_a;
  logic [31:0]        w_abs_b;
  logic [32:0]        w_shift;
  logic [32:0]        w_trial;
  logic [63:0]        w_mul_res;
  logic [31:0]        w_quo_fix;
  logic [31:0]        w_rem_fix;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    case (op)
      OP_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OP_MULTU: w_is_mul = 1'b1;
      OP_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      OP_DIVU:  w_is_div = 1'b1;
`ifdef HILO_ACCUMULATE_EN
      OP_MADD, OP_MSUB:   begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OP_MADDU, OP_MSUBU: w_is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef HILO_ACCUMULATE_EN
  always_comb begin
    w_acc = 2'b00;
    if (op == OP_MADD || op == OP_MADDU)
      w_acc = 2'b01;
    else if (op == OP_MSUB || op == OP_MSUBU)
      w_acc = 2'b10;
  end
`endif

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = start & ~flush & w_idle;

  // Operand preparation: one 64x64 multiply serves both signednesses via extension.
  assign w_mul_a = {{32{w_signed & rs_value[31]}}, rs_value};
  assign w_mul_b = {{32{w_signed & rt_value[31]}}, rt_value};
  assign w_prod  = w_mul_a * w_mul_b;
  assign w_abs_a = (w_signed & rs_value[31]) ? (32'd0 - rs_value) : rs_value;
  assign w_abs_b = (w_signed & rt_value[31]) ? (32'd0 - rt_value) : rt_value;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  // Operand/iteration datapath: no reset, contents only meaningful while busy.
  always_ff @(posedge clk) begin
    if (w_accept & (w_is_mul | w_is_div)) begin
      r_prod  <= w_prod;
      r_a     <= rs_value;
      r_div0  <= (rt_value == 32'd0);
      r_neg_a <= w_signed & rs_value[31];
      r_neg_b <= w_signed & rt_value[31];
      r_quo   <= w_abs_a;
      r_dvs   <= w_abs_b;
      r_rem   <= 32'd0;
`ifdef HILO_ACCUMULATE_EN
      r_acc   <= w_acc;
`endif
    end else if (r_state == S_DIV) begin
      if (!w_trial[32]) begin
        r_rem <= w_trial[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shift[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

`ifdef HILO_ACCUMULATE_EN
  always_comb begin
    case (r_acc)
      2'b01:   w_mul_res = {r_hi, r_lo} + r_prod;
      2'b10:   w_mul_res = {r_hi, r_lo} - r_prod;
      default: w_mul_res = r_prod;
    endcase
  end
`else
  assign w_mul_res = r_prod;
`endif

  // Sign fix-up stage; divide-by-zero bypasses the iterated result entirely.
  assign w_quo_fix = r_div0 ? 32'hFFFF_FFFF :
                     ((r_neg_a ^ r_neg_b) ? (32'd0 - r_quo) : r_quo);
  assign w_rem_fix = r_div0 ? r_a : (r_neg_a ? (32'd0 - r_rem) : r_rem);

  assign w_mul_done = ~flush & (r_state == S_MUL) & (r_cnt == '0);
  assign w_div_done = ~flush & (r_state == S_FIX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept & w_is_mul)
          w_next = S_MUL;
        else if (w_accept & w_is_div)
          w_next = S_DIV;
      end
      S_MUL: begin
        if (flush || r_cnt == '0)
          w_next = S_IDLE;
      end
      S_DIV: begin
        if (flush)
          w_next = S_IDLE;
        else if (r_cnt == '0)
          w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state != S_IDLE);
    stall = busy & (start | read_hilo);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= w_mul_done | w_div_done;
      if (w_accept && op == OP_MTHI)
        r_hi <= rs_value;
      if (w_accept && op == OP_MTLO)
        r_lo <= rs_value;
      if (w_mul_done)
        {r_hi, r_lo} <= w_mul_res;
      if (w_div_done) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end
      if (w_accept & w_is_mul)
        r_cnt <= CNT_W'(MUL_CYCLES - 1);
      else if (w_accept & w_is_div)
        r_cnt <= CNT_W'(DIV_ITER - 1);
      else if (flush & ~w_idle)
        r_cnt <= '0;
      else if ((r_state == S_MUL || r_state == S_DIV) && r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Testbench for hilo_muldiv_sequencer: arithmetic/latency model plus directed literal checks.
// Accumulate cases are exercised when HILO_ACCUMULATE_EN is defined.
module tb_hilo_muldiv_sequencer;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_LAT    = 33;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_value = 32'd0;
  logic [31:0] rt_value = 32'd0;
  logic        read_hilo = 1'b0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_busy  = 0;
  int b0, d0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic [1:0]  m_kind;
  int          m_left;
  logic        m_done;

  always #5 clk = ~clk;

  hilo_muldiv_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITER(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_value(rs_value), .rt_value(rt_value), .read_hilo(read_hilo),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return 64'(sa * sb);
  endfunction

  // Returns {remainder, quotient}; SV '/' truncates toward zero and '%' follows the dividend sign.
  function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0; m_done <= 1'b0;
      m_res <= 64'd0; m_kind <= 2'd0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (flush)
          m_left <= 0;
        else if (m_left == 1) begin
          m_left <= 0;
          m_done <= 1'b1;
          case (m_kind)
            2'd1:    {m_hi, m_lo} <= {m_hi, m_lo} + m_res;
            2'd2:    {m_hi, m_lo} <= {m_hi, m_lo} - m_res;
            default: {m_hi, m_lo} <= m_res;
          endcase
        end else
          m_left <= m_left - 1;
      end else if (start && !flush) begin
        case (op)
          4'd1: begin m_res <= f_mul(rs_value, rt_value, 1'b1); m_kind <= 2'd0; m_left <= MUL_CYCLES; end
          4'd2: begin m_res <= f_mul(rs_value, rt_value, 1'b0); m_kind <= 2'd0; m_left <= MUL_CYCLES; end
          4'd3: begin m_res <= f_div(rs_value, rt_value, 1'b1); m_kind <= 2'd0; m_left <= DIV_LAT; end
          4'd4: begin m_res <= f_div(rs_value, rt_value, 1'b0); m_kind <= 2'd0; m_left <= DIV_LAT; end
          4'd5: m_hi <= rs_value;
          4'd6: m_lo <= rs_value;
`ifdef HILO_ACCUMULATE_EN
          4'd7:  begin m_res <= f_mul(rs_value, rt_value, 1'b1); m_kind <= 2'd1; m_left <= MUL_CYCLES; end
          4'd8:  begin m_res <= f_mul(rs_value, rt_value, 1'b0); m_kind <= 2'd1; m_left <= MUL_CYCLES; end
          4'd9:  begin m_res <= f_mul(rs_value, rt_value, 1'b1); m_kind <= 2'd2; m_left <= MUL_CYCLES; end
          4'd10: begin m_res <= f_mul(rs_value, rt_value, 1'b0); m_kind <= 2'd2; m_left <= MUL_CYCLES; end
`endif
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) n_busy++;
      if (done) n_done++;
      chk("cmp.busy",  64'(busy),  64'(m_left != 0));
      chk("cmp.done",  64'(done),  64'(m_done));
      chk("cmp.stall", 64'(stall), 64'((m_left != 0) && (start || read_hilo)));
      chk("cmp.hi",    64'(hi),    64'(m_hi));
      chk("cmp.lo",    64'(lo),    64'(m_lo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_value = a; rt_value = b;
    tick();
    start = 1'b0; op = 4'd0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy || m_left != 0) && c < 200) begin
      tick();
      c++;
    end
    chk("wait_idle.busy", 64'(busy), 64'd0);
  endtask

  task automatic check_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    chk({nm, ".hi"}, 64'(hi), 64'(eh));
    chk({nm, ".lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    #12;
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.stall", 64'(stall), 64'd0);
    #10 reset_n = 1'b1;
    tick();

    b0 = n_busy; d0 = n_done;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(); tick();
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    chk("mult.busy_cycles", 64'(n_busy - b0), 64'd4);
    chk("mult.done_pulses", 64'(n_done - d0), 64'd1);

    b0 = n_busy; d0 = n_done;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(); tick();
    check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("div.busy_cycles", 64'(n_busy - b0), 64'd33);
    chk("div.done_pulses", 64'(n_done - d0), 64'd1);

    issue(4'd4, 32'd100, 32'd7);
    wait_idle(); tick();
    check_hilo("divu", 32'd2, 32'd14);

    b0 = n_busy;
    issue(4'd4, 32'h0000_1234, 32'd0);
    wait_idle(); tick();
    check_hilo("divu_by0", 32'h0000_1234, 32'hFFFF_FFFF);
    chk("div0.busy_cycles", 64'(n_busy - b0), 64'd33);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(); tick();
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);

    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(); tick();
    check_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

    // MFHI during DIV, plus a MULT held by decode until the stall drops.
    issue(4'd3, 32'd50, 32'hFFFF_FFFD);
    repeat (3) tick();
    read_hilo = 1'b1;
    #1;
    chk("stall.read", 64'(stall), 64'd1);
    check_hilo("stall.old", 32'hFFFF_FFFE, 32'h0000_0001);
    repeat (3) tick();
    start = 1'b1; op = 4'd1; rs_value = 32'd6; rt_value = 32'd7;
    #1;
    chk("stall.start", 64'(stall), 64'd1);
    wait_idle();
    chk("stall.released", 64'(stall), 64'd0);
    check_hilo("div_mixed", 32'd2, 32'hFFFF_FFF0);
    tick();
    start = 1'b0; op = 4'd0; read_hilo = 1'b0;
    chk("represent.busy", 64'(busy), 64'd1);
    wait_idle(); tick();
    check_hilo("represent", 32'd0, 32'd42);

    issue(4'd5, 32'hA5A5_A5A5, 32'd0);
    issue(4'd3, 32'd100, 32'd3);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_div.busy", 64'(busy), 64'd0);
    check_hilo("flush_div", 32'hA5A5_A5A5, 32'd42);
    d0 = n_done;
    repeat (40) tick();
    chk("flush_div.no_done", 64'(n_done - d0), 64'd0);

    flush = 1'b1; start = 1'b1; op = 4'd6; rs_value = 32'h0000_DEAD;
    tick();
    flush = 1'b0; start = 1'b0; op = 4'd0;
    chk("flush_start.lo", 64'(lo), 64'd42);

    d0 = n_done;
    issue(4'd1, 32'd5, 32'd5);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_complete.busy", 64'(busy), 64'd0);
    check_hilo("flush_complete", 32'hA5A5_A5A5, 32'd42);
    tick();
    chk("flush_complete.no_done", 64'(n_done - d0), 64'd0);

    issue(4'd11, 32'd1, 32'd2);
    chk("illegal11.busy", 64'(busy), 64'd0);
    issue(4'd0, 32'd1, 32'd2);
    chk("none.busy", 64'(busy), 64'd0);
    issue(4'd15, 32'd1, 32'd2);
    chk("illegal15.busy", 64'(busy), 64'd0);
    check_hilo("illegal", 32'hA5A5_A5A5, 32'd42);

`ifdef HILO_ACCUMULATE_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd10, 32'd0);
    issue(4'd7, 32'hFFFF_FFFF, 32'd4);
    wait_idle(); tick();
    check_hilo("madd", 32'd0, 32'd6);
    issue(4'd10, 32'd1, 32'd7);
    wait_idle(); tick();
    check_hilo("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    issue(4'd7, 32'hFFFF_FFFF, 32'd4);
    chk("madd_off.busy", 64'(busy), 64'd0);
    check_hilo("madd_off", 32'hA5A5_A5A5, 32'd42);
`endif

    issue(4'd1, 32'd3, 32'd3);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst.hi", 64'(hi), 64'd0);
    chk("async_rst.lo", 64'(lo), 64'd0);
    chk("async_rst.busy", 64'(busy), 64'd0);
    chk("async_rst.done", 64'(done), 64'd0);
    chk("async_rst.stall", 64'(stall), 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    tick(); tick();
    chk("post_rst.busy", 64'(busy), 64'd0);
    check_hilo("post_rst", 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
